// File: rtl/hamming_byte_assembler.sv
// Hamming(7,4) decoder that corrects single-bit errors, pairs decoded nibbles
// into bytes (low nibble first) and queues them in a small ready/valid FIFO.
module hamming_byte_assembler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PAIR_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [6:0]                    cw_in,
  input  logic                          cw_valid,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    corr_count,
  output logic                          pair_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(PAIR_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ASM_LOW = 1'b0, ASM_HIGH = 1'b1} asm_state_t;

  function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
            cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
            cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

  // A non-zero syndrome is the 1-based position of the flipped bit.
  function automatic logic [3:0] hamming_correct(input logic [6:0] cw);
    logic [2:0] syn;
    logic [6:0] fixed;
    syn   = hamming_syndrome(cw);
    fixed = cw;
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
    end else begin
      fixed = cw;
    end
    return {fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

  logic [2:0]      syn_s;
  logic            dec_valid_r;
  logic [3:0]      dec_nib_r;
  logic [7:0]      corr_count_r;
  asm_state_t      state_r, state_n;
  logic [3:0]      low_r, low_n;
  logic [TW-1:0]   cnt_r, cnt_n;
  logic            push_s, fire_s, pop_s, full_s, accept_s, drop_s;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     level_r;
  logic            overflow_r, pair_err_r;

  assign syn_s = hamming_syndrome(cw_in);

  // Stage 1: decode and register the nibble, count corrections.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_r  <= 1'b0;
      dec_nib_r    <= 4'h0;
      corr_count_r <= 8'h00;
    end else if (ena) begin
      dec_valid_r <= cw_valid;
      if (cw_valid) begin
        dec_nib_r <= hamming_correct(cw_in);
        if ((syn_s != 3'd0) && (corr_count_r != 8'hFF)) begin
          corr_count_r <= corr_count_r + 8'd1;
        end
      end
    end
  end

  // Assembler state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ASM_LOW;
      low_r   <= 4'h0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      low_r   <= low_n;
      cnt_r   <= cnt_n;
    end
  end

  // Assembler next state; a completing nibble beats a simultaneous timeout.
  always_comb begin
    state_n = state_r;
    low_n   = low_r;
    cnt_n   = cnt_r;
    push_s  = 1'b0;
    fire_s  = 1'b0;
    if (ena) begin
      case (state_r)
        ASM_LOW: begin
          if (dec_valid_r) begin
            low_n   = dec_nib_r;
            cnt_n   = '0;
            state_n = ASM_HIGH;
          end else begin
            state_n = ASM_LOW;
          end
        end
        ASM_HIGH: begin
          if (dec_valid_r) begin
            push_s  = 1'b1;
            state_n = ASM_LOW;
          end else if ((PAIR_TIMEOUT != 0) && ((cnt_r + TMO_ONE) == TMO_LIMIT)) begin
            fire_s  = 1'b1;
            cnt_n   = '0;
            state_n = ASM_LOW;
          end else begin
            cnt_n = cnt_r + TMO_ONE;
          end
        end
        default: begin
          state_n = ASM_LOW;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign m_valid  = (level_r != '0);
  assign full_s   = (level_r == FULL_LEVEL);
  assign pop_s    = ena & m_valid & m_ready;
  assign accept_s = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  // Output FIFO, sticky overflow and the timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
      pair_err_r <= 1'b0;
    end else begin
      pair_err_r <= fire_s;
      if (accept_s) begin
        mem_r[wr_ptr_r] <= {dec_nib_r, low_r};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign m_data     = mem_r[rd_ptr_r];
  assign corr_count = corr_count_r;
  assign pair_err   = pair_err_r;
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Self-checking bench: directed vector table, multi-cycle corner cases and a
// randomized run compared every cycle against a queue-based reference model.
module tb_hamming_byte_assembler;

  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  logic       clk = 1'b0;
  logic       rst, ena, cw_valid, m_ready;
  logic [6:0] cw_in;
  logic [7:0] m_data, corr_count;
  logic       m_valid, pair_err, overflow;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hamming_byte_assembler #(.FIFO_DEPTH(DEPTH), .PAIR_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cw_in(cw_in), .cw_valid(cw_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .corr_count(corr_count), .pair_err(pair_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  // Reference model state
  logic [7:0] mq[$];
  bit         nib_v, have_low, perr, ovf;
  logic [3:0] nib, low;
  int         age, corr;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] c;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    c[0] = n[0] ^ n[1] ^ n[3];
    c[1] = n[0] ^ n[2] ^ n[3];
    c[3] = n[1] ^ n[2] ^ n[3];
    return c;
  endfunction

  // Nearest-codeword decode; the code is perfect so the nearest is unique.
  task automatic mdecode(input logic [6:0] cw, output logic [3:0] n, output bit fixed);
    int best;
    best = 8;
    n = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if ($countones(enc(4'(k)) ^ cw) < best) begin
        best = $countones(enc(4'(k)) ^ cw);
        n = 4'(k);
      end
    end
    fixed = (best != 0);
  endtask

  task automatic model_update();
    logic [3:0] dn;
    bit dc;
    if (rst) begin
      mq.delete();
      nib_v = 0; have_low = 0; age = 0; corr = 0; perr = 0; ovf = 0;
    end else if (!ena) begin
      perr = 0;
    end else begin
      perr = 0;
      if (mq.size() > 0 && m_ready) void'(mq.pop_front());
      if (nib_v) begin
        if (have_low) begin
          if (mq.size() < DEPTH) mq.push_back({nib, low});
          else ovf = 1;
          have_low = 0;
        end else begin
          have_low = 1; low = nib; age = 0;
        end
      end else if (have_low) begin
        age++;
        if (TMO != 0 && age == TMO) begin
          perr = 1; have_low = 0;
        end
      end
      nib_v = cw_valid;
      if (cw_valid) begin
        mdecode(cw_in, dn, dc);
        nib = dn;
        if (dc && corr < 255) corr++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
    chk("corr_count", 32'(corr_count), 32'(corr));
    chk("pair_err", 32'(pair_err), 32'(perr));
    chk("overflow", 32'(overflow), 32'(ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle();
    cw_valid = 1'b0;
    step();
  endtask

  task automatic send(input logic [6:0] cw);
    cw_in = cw;
    cw_valid = 1'b1;
    step();
    cw_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send(enc(b[3:0]));
    send(enc(b[7:4]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0] cw_lo;
    logic [6:0] cw_hi;
    logic [7:0] exp_byte;
    int         corr_inc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int corr_exp, k;
    bit found;
    logic [7:0] exp_list[4];

    vecs[0] = '{7'h2D, 7'h52, 8'hA5, 0};
    vecs[1] = '{7'h2D, 7'h42, 8'hA5, 1};
    vecs[2] = '{7'h52, 7'h2D, 8'h5A, 0};
    vecs[3] = '{7'h2C, 7'h52, 8'hA5, 1};
    vecs[4] = '{7'h00, 7'h7F, 8'hF0, 0};
    vecs[5] = '{7'h7E, 7'h01, 8'h0F, 2};

    rst = 1'b1; ena = 1'b1; cw_valid = 1'b0; cw_in = 7'h00; m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_corr", 32'(corr_count), 32'd0);
    chk("rst_pair_err", 32'(pair_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);

    // Vector table: pair, latency and correction count
    m_ready = 1'b1;
    corr_exp = 0;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].cw_lo);
      send(vecs[i].cw_hi);
      chk("vec_lat_n1", 32'(m_valid), 32'd0);
      idle();
      corr_exp += vecs[i].corr_inc;
      chk("vec_m_valid", 32'(m_valid), 32'd1);
      chk("vec_byte", 32'(m_data), 32'(vecs[i].exp_byte));
      chk("vec_corr", 32'(corr_count), 32'(corr_exp));
      idle();
      chk("vec_one_cycle", 32'(m_valid), 32'd0);
    end

    // Saturation of the correction counter
    for (int i = 0; i < 300; i++) send(7'h42);
    idle();
    idle();
    chk("corr_saturate", 32'(corr_count), 32'd255);

    // Pair timeout, then the next codeword becomes the low nibble
    do_reset();
    send(7'h2D);
    k = 0;
    found = 0;
    while (k < 40 && !found) begin
      idle();
      k++;
      if (pair_err) found = 1;
    end
    chk("tmo_cycles", 32'(k), 32'd11);
    idle();
    chk("tmo_one_pulse", 32'(pair_err), 32'd0);
    send(7'h52);
    send(7'h2D);
    idle();
    chk("tmo_after_m_valid", 32'(m_valid), 32'd1);
    chk("tmo_after_byte", 32'(m_data), 32'h5A);
    idle();

    // Overflow with a stalled consumer, then in-order drain
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 17));
    idle();
    idle();
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", 32'(m_data), 32'(i * 17));
      idle();
    end
    chk("ovf_empty", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Push and pop together on a full FIFO, three times around
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    idle();
    for (int r = 0; r < 3; r++) begin
      send_byte(8'hD0 + 8'(r));
      m_ready = 1'b1;
      idle();
      m_ready = 1'b0;
      chk("wrap_level", 32'(fifo_level), 32'd4);
      chk("wrap_no_ovf", 32'(overflow), 32'd0);
    end
    exp_list[0] = 8'hC3; exp_list[1] = 8'hD0; exp_list[2] = 8'hD1; exp_list[3] = 8'hD2;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain", 32'(m_data), 32'(exp_list[i]));
      idle();
    end
    chk("wrap_empty", 32'(m_valid), 32'd0);

    // Reset with a pending nibble and two buffered bytes
    m_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    idle();
    send(7'h2D);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_corr", 32'(corr_count), 32'd0);
    m_ready = 1'b1;
    send(7'h2D);
    send(7'h52);
    idle();
    chk("mid_rst_byte_v", 32'(m_valid), 32'd1);
    chk("mid_rst_byte", 32'(m_data), 32'hA5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] err;
      int rate;
      rate = ((i / 500) % 3 == 0) ? 70 : (((i / 500) % 3 == 1) ? 20 : 5);
      ena = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 99) < 60);
      rst = ($urandom_range(0, 399) == 0);
      cw_valid = ($urandom_range(0, 99) < rate);
      err = 7'h00;
      case ($urandom_range(0, 2))
        0: err = 7'h00;
        1: err[$urandom_range(0, 6)] = 1'b1;
        default: begin
          err[$urandom_range(0, 6)] = 1'b1;
          err[$urandom_range(0, 6)] = 1'b1;
        end
      endcase
      cw_in = enc(4'($urandom_range(0, 15))) ^ err;
      step();
    end
    rst = 1'b0;
    ena = 1'b1;
    cw_valid = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_byte_assembler.md
Name: hamming_byte_assembler

Overview:
Sits directly downstream of the UART receiver. Consumes each 7-bit Hamming(7,4) codeword when the receiver's valid strobe fires and corrects any single-bit error. Pairs successive decoded nibbles into bytes, low nibble first, and buffers completed bytes in a small FIFO with a ready/valid output. Keeps correction and error statistics for debug.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the output FIFO; power of 2, range 2..16.
PAIR_TIMEOUT, 255, enabled cycles allowed between first and second nibble before the pending low nibble is discarded; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ena  input  1  enable; when low, all state holds (FIFO, counters, timeout) and cw_valid/m_ready are ignored
cw_in  input  7  received codeword; cw_in[0] is the first bit on the line
cw_valid  input  1  one-cycle strobe; cw_in is valid this cycle
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid & m_ready & ena
corr_count  output  8  saturating count of corrected codewords
pair_err  output  1  one-cycle pulse when a pending nibble times out
overflow  output  1  sticky; a completed byte was dropped because the FIFO was full
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: all outputs 0, FIFO empty, no nibble pending, timeout counter 0. Reset wins over every other event in the same cycle and abandons a pending nibble or an in-flight decode.
- Codeword layout: cw[0]=p1, cw[1]=p2, cw[2]=d1, cw[3]=p4, cw[4]=d2, cw[5]=d3, cw[6]=d4. The nibble is {d4,d3,d2,d1}.
- Syndrome: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6, S={s4,s2,s1}.
- If S≠0, flip cw[S-1] before extracting the nibble and increment corr_count, saturating at 255.
- Double-bit errors are miscorrected silently. This is inherent to the code and is not flagged.
- Pipeline stage 1: on cw_valid & ena, decode and register the nibble and a dec_valid flag in the same cycle.
- Pipeline stage 2: the assembler FSM consumes dec_valid.
- Assembler FSM, state LOW:
  - On dec_valid, store the nibble as the low half, clear the timeout counter, go to HIGH.
- Assembler FSM, state HIGH:
  - On dec_valid, form byte {nibble, low}, push it to the FIFO, go to LOW.
  - Otherwise, while ena, increment the timeout counter.
  - If PAIR_TIMEOUT≠0 and the counter reaches PAIR_TIMEOUT, pulse pair_err for one cycle, discard the low half, go to LOW.
  - If dec_valid and the timeout fire in the same cycle, dec_valid wins: the byte completes and there is no pair_err.
- Latency: second codeword's cw_valid at cycle N gives m_valid=1 with the byte on m_data at cycle N+2, when the FIFO was empty.
- Back-to-back cw_valid on consecutive cycles must be supported.
- FIFO storage: circular buffer with pointer wrap at FIFO_DEPTH.
  - m_data is the head entry, combinationally from storage.
  - Pop on m_valid & m_ready & ena.
- FIFO push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs the same cycle; occupancy is then unchanged.
  - A push to a full FIFO with no pop drops the byte and sets overflow, which stays set until rst.
  - The assembler still returns to LOW after a dropped push.
- FIFO pop rules:
  - A pop with m_valid=0 has no effect.
  - Simultaneous push and pop on an empty FIFO: the push is stored and m_valid rises the next cycle. There is no fall-through.

Test Plan:
1. Reset, then cw 0x2D followed by cw 0x52 with m_ready=1 -> m_data=0xA5 with a one-cycle m_valid two cycles after the 2nd strobe; corr_count=0.
2. Send 0x2D then 0x42 (0x52 with bit4 flipped; S=5) -> byte 0xA5, corr_count=1. Repeat 300 corrupted words -> corr_count holds 255.
3. With PAIR_TIMEOUT=10, send 0x2D and then idle -> pair_err pulses once 10 cycles later. Then send 0x52, 0x2D -> byte 0x5A (0x52 is now the low nibble).
4. With m_ready=0, send 5 byte-pairs (FIFO_DEPTH=4) -> fifo_level=4, overflow=1, and the first 4 bytes drain in order once m_ready=1.
5. With the FIFO full, raise m_ready on the same cycle a byte completes -> level stays 4, no overflow, pointers wrap correctly across 3 full cycles.
6. Assert rst while a nibble is pending and the FIFO holds 2 bytes -> next cycle all outputs are 0 and m_valid=0. A following pair 0x2D, 0x52 yields 0xA5.
